// File: rtl/instr_reg_fetch_pkg.sv
// Shared CPU definitions for the fetch front end: word geometry, IR field
// positions and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int WORD_WIDTH   = 16;
    localparam int OPCODE_WIDTH = 7;
    localparam int FIELD_WIDTH  = 3;
    localparam int IMM_FLAG_BIT = 15;

    localparam int OPCODE_LSB = 9;
    localparam int OP2_LSB    = 6;
    localparam int OP1_LSB    = 3;
    localparam int OP0_LSB    = 0;

    typedef logic [WORD_WIDTH-1:0] wordT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_IR  = 2'd1,
        GAP     = 2'd2,
        REQ_IMM = 2'd3
    } fetchStateT;

    function automatic logic hasImmediate(input wordT word);
        return word[IMM_FLAG_BIT];
    endfunction

endpackage

// File: rtl/instr_reg_fetch_if.sv
// Fetch bus: microsequencer request/abort, memory read handshake and the
// decoded instruction fields presented to the register-select stage.
interface instr_reg_fetch_if;
    import cpu_pkg::*;

    logic                    fetchStart;
    logic                    abort;
    logic                    memAck;
    wordT                    memData;
    logic                    memReq;
    logic                    pcInc;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FIELD_WIDTH-1:0]  op2;
    logic [FIELD_WIDTH-1:0]  op1;
    logic [FIELD_WIDTH-1:0]  op0;
    wordT                    immediate;
    logic                    irValid;
    logic                    busy;

    // The fetch unit itself.
    modport slave (
        input  fetchStart, abort, memAck, memData,
        output memReq, pcInc, opcode, op2, op1, op0, immediate, irValid, busy
    );

    // Microsequencer plus memory, as seen from the fetch unit.
    modport master (
        output fetchStart, abort, memAck, memData,
        input  memReq, pcInc, opcode, op2, op1, op0, immediate, irValid, busy
    );

endinterface

// File: rtl/instr_reg_fetch_latch.sv
// Word-wide holding register with async clear, sync clear and sync load;
// used for both the instruction register and the immediate register.
module ir_word_latch
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values; blocking assignments here would race the readers.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_reg_fetch.sv
// Instruction register and fetch sequencer: fetches an instruction word and an
// optional trailing immediate, then presents opcode and operand fields.
module instr_reg_fetch
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               notReset,
    instr_reg_fetch_if.slave   bus
);

    fetchStateT state;
    fetchStateT nextState;

    logic acceptIr;
    logic acceptImm;
    logic setValid;
    logic clearValid;
    logic clearImm;

    logic pcIncQ;
    logic irValidQ;
    wordT irQ;
    wordT immQ;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState  = state;
        acceptIr   = 1'b0;
        acceptImm  = 1'b0;
        setValid   = 1'b0;
        clearValid = 1'b0;
        clearImm   = 1'b0;

        // Abort outranks everything, including a coincident memAck.
        if (bus.abort) begin
            nextState  = IDLE;
            clearValid = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.fetchStart) begin
                        nextState  = REQ_IR;
                        clearValid = 1'b1;
                    end
                end
                REQ_IR: begin
                    if (bus.memAck) begin
                        acceptIr = 1'b1;
                        if (hasImmediate(bus.memData)) begin
                            nextState = GAP;
                        end else begin
                            nextState = IDLE;
                            clearImm  = 1'b1;
                            setValid  = 1'b1;
                        end
                    end
                end
                GAP: begin
                    nextState = REQ_IMM;
                end
                REQ_IMM: begin
                    if (bus.memAck) begin
                        acceptImm = 1'b1;
                        setValid  = 1'b1;
                        nextState = IDLE;
                    end
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Accepted words are at least two cycles apart, so this pulse can never
    // stretch across consecutive cycles.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            pcIncQ   <= 1'b0;
            irValidQ <= 1'b0;
        end else begin
            pcIncQ <= acceptIr | acceptImm;
            if (clearValid) begin
                irValidQ <= 1'b0;
            end else if (setValid) begin
                irValidQ <= 1'b1;
            end
        end
    end

    ir_word_latch #(.WIDTH(WORD_WIDTH)) irLatch (
        .clock    (clock),
        .notReset (notReset),
        .clear    (1'b0),
        .load     (acceptIr),
        .d        (bus.memData),
        .q        (irQ)
    );

    ir_word_latch #(.WIDTH(WORD_WIDTH)) immLatch (
        .clock    (clock),
        .notReset (notReset),
        .clear    (clearImm),
        .load     (acceptImm),
        .d        (bus.memData),
        .q        (immQ)
    );

    // memReq decodes straight from the state register, so an async reset
    // drops it without waiting for an edge.
    assign bus.memReq    = (state == REQ_IR) || (state == REQ_IMM);
    assign bus.busy      = (state != IDLE);
    assign bus.pcInc     = pcIncQ;
    assign bus.irValid   = irValidQ;
    assign bus.immediate = immQ;

    assign bus.opcode = irQ[OPCODE_LSB +: OPCODE_WIDTH];
    assign bus.op2    = irQ[OP2_LSB +: FIELD_WIDTH];
    assign bus.op1    = irQ[OP1_LSB +: FIELD_WIDTH];
    assign bus.op0    = irQ[OP0_LSB +: FIELD_WIDTH];

endmodule
